q_update_ctrl: RTL and testbench

//  Sequences one Q-learning update per accepted (state, next_state, action, reward) tuple.

---
 rtl/q_update_ctrl.sv | 142 ++++++++++++++
 tb/tb_q_update_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update_ctrl.sv
// Serial Q-learning update sequencer: reads Q[s][a], scans Q[s'][*] for the signed max,
// hands the operands to the compute unit and writes the result back to Q[s][a].
module q_update_ctrl #(
  parameter int STATES_WIDTH  = 8,
  parameter int ACTIONS_WIDTH = 2,
  parameter int NUM_ACTIONS   = 4,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [STATES_WIDTH-1:0]               in_state,
  input  logic [STATES_WIDTH-1:0]               in_next,
  input  logic [ACTIONS_WIDTH-1:0]              in_action,
  input  logic [DATA_WIDTH-1:0]                 in_reward,
  input  logic                                  stop,
  output logic                                  q_rd_en,
  output logic [STATES_WIDTH+ACTIONS_WIDTH-1:0] q_rd_addr,
  input  logic [DATA_WIDTH-1:0]                 q_rd_data,
  output logic                                  calc_start,
  output logic [DATA_WIDTH-1:0]                 calc_q_sa,
  output logic [DATA_WIDTH-1:0]                 calc_q_max,
  output logic [DATA_WIDTH-1:0]                 calc_reward,
  input  logic                                  calc_done,
  input  logic [DATA_WIDTH-1:0]                 calc_q_new,
  output logic                                  q_wr_en,
  output logic [STATES_WIDTH+ACTIONS_WIDTH-1:0] q_wr_addr,
  output logic [DATA_WIDTH-1:0]                 q_wr_data,
  output logic                                  busy,
  output logic                                  done,
  output logic [31:0]                           update_count
);

  localparam int CW = $clog2(NUM_ACTIONS + 1);
  localparam logic [CW-1:0] LAST_RD   = CW'(NUM_ACTIONS - 1);
  localparam logic [CW-1:0] LAST_FOLD = CW'(NUM_ACTIONS);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_SA, S_RD_MAX, S_CALC, S_WAIT, S_WR, S_DONE
  } state_t;

  state_t                     state;
  logic [STATES_WIDTH-1:0]    s_r;
  logic [STATES_WIDTH-1:0]    n_r;
  logic [ACTIONS_WIDTH-1:0]   a_r;
  logic [CW-1:0]              idx;
  logic                       stop_pend;

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign done     = (state == S_DONE);
  assign in_ready = (state == S_IDLE) && !stop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      s_r          <= '0;
      n_r          <= '0;
      a_r          <= '0;
      idx          <= '0;
      stop_pend    <= 1'b0;
      q_rd_en      <= 1'b0;
      q_rd_addr    <= '0;
      calc_start   <= 1'b0;
      calc_q_sa    <= '0;
      calc_q_max   <= '0;
      calc_reward  <= '0;
      q_wr_en      <= 1'b0;
      q_wr_addr    <= '0;
      q_wr_data    <= '0;
      update_count <= '0;
    end else begin
      q_rd_en    <= 1'b0;
      calc_start <= 1'b0;
      q_wr_en    <= 1'b0;
      if (stop && state != S_IDLE && state != S_DONE) stop_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (stop) begin
            state <= S_DONE;
          end else if (in_valid) begin
            s_r         <= in_state;
            n_r         <= in_next;
            a_r         <= in_action;
            calc_reward <= in_reward;
            stop_pend   <= 1'b0;
            q_rd_en     <= 1'b1;
            q_rd_addr   <= {in_state, in_action};
            state       <= S_RD_SA;
          end
        end
        S_RD_SA: begin
          q_rd_en   <= 1'b1;
          q_rd_addr <= {n_r, {ACTIONS_WIDTH{1'b0}}};
          idx       <= '0;
          state     <= S_RD_MAX;
        end
        S_RD_MAX: begin
          // Read data lags the address by one cycle: slot 0 returns Q[s][a],
          // slot j>=1 returns Q[s'][j-1]; the first s' value seeds the max.
          if (idx == '0) begin
            calc_q_sa <= q_rd_data;
          end else if (idx == CW'(1) || $signed(q_rd_data) > $signed(calc_q_max)) begin
            calc_q_max <= q_rd_data;
          end
          if (idx < LAST_RD) begin
            q_rd_en   <= 1'b1;
            q_rd_addr <= {n_r, ACTIONS_WIDTH'(idx + 1'b1)};
          end
          if (idx == LAST_FOLD) begin
            calc_start <= 1'b1;
            state      <= S_CALC;
          end
          idx <= idx + 1'b1;
        end
        S_CALC: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (calc_done) begin
            q_wr_data <= calc_q_new;
            q_wr_addr <= {s_r, a_r};
            q_wr_en   <= 1'b1;
            state     <= S_WR;
          end
        end
        S_WR: begin
          update_count <= update_count + 32'd1;
          state        <= (stop_pend || stop) ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_update_ctrl.sv
// Bench for q_update_ctrl: Q-table RAM and compute-unit responders, directed vector table,
// multi-cycle corner sequences and randomized tuples against a shadow Q-table model.
module tb_q_update_ctrl;

  localparam int SW = 8;
  localparam int AW = 2;
  localparam int NA = 4;
  localparam int DW = 16;
  localparam int QA = SW + AW;
  localparam int NV = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_state = '0;
  logic [SW-1:0] in_next = '0;
  logic [AW-1:0] in_action = '0;
  logic [DW-1:0] in_reward = '0;
  logic          stop = 1'b0;
  logic          q_rd_en;
  logic [QA-1:0] q_rd_addr;
  logic [DW-1:0] q_rd_data = '0;
  logic          calc_start;
  logic [DW-1:0] calc_q_sa;
  logic [DW-1:0] calc_q_max;
  logic [DW-1:0] calc_reward;
  logic          calc_done = 1'b0;
  logic [DW-1:0] calc_q_new = '0;
  logic          q_wr_en;
  logic [QA-1:0] q_wr_addr;
  logic [DW-1:0] q_wr_data;
  logic          busy;
  logic          done;
  logic [31:0]   update_count;

  always #5 clk = ~clk;

  q_update_ctrl #(
    .STATES_WIDTH (SW),
    .ACTIONS_WIDTH(AW),
    .NUM_ACTIONS  (NA),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_next(in_next), .in_action(in_action), .in_reward(in_reward),
    .stop(stop),
    .q_rd_en(q_rd_en), .q_rd_addr(q_rd_addr), .q_rd_data(q_rd_data),
    .calc_start(calc_start), .calc_q_sa(calc_q_sa), .calc_q_max(calc_q_max),
    .calc_reward(calc_reward), .calc_done(calc_done), .calc_q_new(calc_q_new),
    .q_wr_en(q_wr_en), .q_wr_addr(q_wr_addr), .q_wr_data(q_wr_data),
    .busy(busy), .done(done), .update_count(update_count)
  );

  logic [DW-1:0] mem   [0:(1<<QA)-1];
  logic [DW-1:0] model [0:(1<<QA)-1];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Responder: sample DUT strobes mid-cycle, apply RAM/compute responses just after the edge.
  int unsigned   calc_L = 1;
  bit            stray_en = 1'b0;
  int unsigned   wr_total = 0;
  int unsigned   cd_cnt = 0;
  logic          rp, wp;
  logic [QA-1:0] ra, wa;
  logic [DW-1:0] wd, ssa, smx, srw;

  always begin
    @(negedge clk);
    rp = q_rd_en; ra = q_rd_addr;
    wp = q_wr_en; wa = q_wr_addr; wd = q_wr_data;
    ssa = calc_q_sa; smx = calc_q_max; srw = calc_reward;
    if (calc_start) cd_cnt = calc_L;
    @(posedge clk);
    #1;
    q_rd_data = rp ? mem[ra] : DW'($urandom);
    if (wp) begin
      mem[wa] = wd;
      wr_total++;
    end
    calc_done  = 1'b0;
    calc_q_new = DW'($urandom);
    if (cd_cnt > 0) begin
      cd_cnt--;
      if (cd_cnt == 0) begin
        calc_done  = 1'b1;
        calc_q_new = srw + smx - ssa;
      end
    end else if (stray_en && $urandom_range(0, 3) == 0) begin
      calc_done = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    stop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offers one tuple at a negedge and follows it to its write-back (returns at the WR negedge).
  task automatic run_tuple(input logic [SW-1:0] s, input logic [SW-1:0] n,
                           input logic [AW-1:0] a, input logic [DW-1:0] r,
                           input int unsigned L, input int unsigned stop_at,
                           output logic [DW-1:0] o_sa, output logic [DW-1:0] o_mx,
                           output logic [DW-1:0] o_r, output logic [QA-1:0] o_wa,
                           output logic [DW-1:0] o_wd, output int unsigned lat,
                           output int unsigned start_cyc, output int unsigned acc_wait,
                           output logic ok);
    int unsigned cyc;
    o_sa = '0; o_mx = '0; o_r = '0; o_wa = '0; o_wd = '0;
    lat = 0; start_cyc = 0; acc_wait = 0; ok = 1'b1;
    in_state = s; in_next = n; in_action = a; in_reward = r; in_valid = 1'b1;
    calc_L = L;
    while (!in_ready && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    if (!in_ready) begin
      ok = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_state  = SW'($urandom);
    in_next   = SW'($urandom);
    in_action = AW'($urandom);
    in_reward = DW'($urandom);
    cyc = 1;
    while (!q_wr_en && cyc < 60) begin
      if (cyc == stop_at) stop = 1'b1;
      else if (stop_at != 0 && cyc == stop_at + 1) stop = 1'b0;
      if (calc_start) begin
        o_sa = calc_q_sa; o_mx = calc_q_max; o_r = calc_reward;
        start_cyc = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    stop = 1'b0;
    if (!q_wr_en) begin
      ok = 1'b0;
    end else begin
      o_wa = q_wr_addr;
      o_wd = q_wr_data;
      lat  = cyc;
    end
  endtask

  typedef struct {
    logic [SW-1:0] s;
    logic [SW-1:0] n;
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    int unsigned   L;
    logic [DW-1:0] row [NA];
    logic [DW-1:0] qsa;
    logic [DW-1:0] e_max;
    logic [DW-1:0] e_new;
    int unsigned   e_lat;
  } vec_t;

  vec_t vecs [NV];

  task automatic setv(input int i, input int s, input int n, input int a, input int r,
                      input int L, input int r0, input int r1, input int r2, input int r3,
                      input int qsa, input int emax, input int enew, input int elat);
    vecs[i].s = SW'(s);   vecs[i].n = SW'(n);   vecs[i].a = AW'(a);
    vecs[i].r = DW'(r);   vecs[i].L = L;
    vecs[i].row[0] = DW'(r0); vecs[i].row[1] = DW'(r1);
    vecs[i].row[2] = DW'(r2); vecs[i].row[3] = DW'(r3);
    vecs[i].qsa = DW'(qsa); vecs[i].e_max = DW'(emax); vecs[i].e_new = DW'(enew);
    vecs[i].e_lat = elat;
  endtask

  logic [DW-1:0] o_sa, o_mx, o_r, o_wd, e_sa, e_mx, e_new, v;
  logic [QA-1:0] o_wa, e_wa;
  int unsigned   lat, st_cyc, acc_w, acc_w1, w0, exp_cnt, rd_seen, rdy_seen, wr_seen, L;
  logic          ok;
  logic [SW-1:0] rs, rn;
  logic [AW-1:0] ra_r;
  logic [DW-1:0] rr;

  initial begin
    for (int i = 0; i < (1 << QA); i++) mem[i] = DW'(int'($urandom_range(0, 2000)) - 1000);

    //            s    n    a   r    L  row                       qsa     max    new    lat
    setv(0,       3,   5,   1,  10,  1, -4,   7,   7,  2,         20,     7,     -3,    9);
    setv(1,       7,   9,   2,  -6,  2, -9,  -3,  -8, -5,          4,    -3,    -13,   10);
    setv(2,      12,  12,   3, 100,  1,  1,   2,   3, 50,         50,    50,    100,    9);
    setv(3,      20,  21,   0,   0,  4,  5,   5,  -1,  5,     -32768,     5, -32763,   12);
    setv(4,       1,   2,   3,   1,  1, -100, -50, 0, 32767,      -1, 32767, -32767,    9);
    setv(5,     200, 201,   2,  -7,  3, 300, -300, 299, 0,         7,   300,    286,   11);
    setv(6,      50,  60,   0,   2,  1, -5,  10,   3, 11,          1,    11,     12,    9);

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_q_rd_en", 32'(q_rd_en), 32'd0);
    chk("rst_q_wr_en", 32'(q_wr_en), 32'd0);
    chk("rst_calc_start", 32'(calc_start), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_update_count", update_count, 32'd0);
    chk("rst_q_rd_addr", 32'(q_rd_addr), 32'd0);
    chk("rst_q_wr_data", 32'(q_wr_data), 32'd0);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < NA; k++) mem[{vecs[i].n, AW'(k)}] = vecs[i].row[k];
      mem[{vecs[i].s, vecs[i].a}] = vecs[i].qsa;
      e_wa = {vecs[i].s, vecs[i].a};
      run_tuple(vecs[i].s, vecs[i].n, vecs[i].a, vecs[i].r, vecs[i].L, 0,
                o_sa, o_mx, o_r, o_wa, o_wd, lat, st_cyc, acc_w, ok);
      chk($sformatf("vec%0d_complete", i), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_calc_q_sa", i), 32'(o_sa), 32'(vecs[i].qsa));
      chk($sformatf("vec%0d_calc_q_max", i), 32'(o_mx), 32'(vecs[i].e_max));
      chk($sformatf("vec%0d_calc_reward", i), 32'(o_r), 32'(vecs[i].r));
      chk($sformatf("vec%0d_wr_addr", i), 32'(o_wa), 32'(e_wa));
      chk($sformatf("vec%0d_wr_data", i), 32'(o_wd), 32'(vecs[i].e_new));
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].e_lat);
      @(negedge clk);
    end
    chk("table_update_count", update_count, 32'(NV));

    // Back-to-back tuples, L=3
    do_reset();
    run_tuple(8'd4, 8'd6, 2'd1, 16'd5, 3, 0, o_sa, o_mx, o_r, o_wa, o_wd, lat, st_cyc, acc_w1, ok);
    chk("b2b_first_complete", 32'(ok), 32'd1);
    chk("b2b_first_accept_wait", acc_w1, 0);
    run_tuple(8'd9, 8'd4, 2'd2, 16'd3, 3, 0, o_sa, o_mx, o_r, o_wa, o_wd, lat, st_cyc, acc_w, ok);
    chk("b2b_second_complete", 32'(ok), 32'd1);
    chk("b2b_second_accept_gap", acc_w, 1);
    chk("b2b_latency", lat, NA + 4 + 3);
    @(negedge clk);
    chk("b2b_update_count", update_count, 32'd2);

    // stop pulsed during RD_MAX: the update completes, then DONE holds
    do_reset();
    w0 = wr_total;
    run_tuple(8'd11, 8'd13, 2'd0, 16'd1, 2, 3, o_sa, o_mx, o_r, o_wa, o_wd, lat, st_cyc, acc_w, ok);
    chk("stop_wr_issued", 32'(ok), 32'd1);
    @(negedge clk);
    chk("stop_done", 32'(done), 32'd1);
    chk("stop_in_ready", 32'(in_ready), 32'd0);
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_update_count", update_count, 32'd1);
    in_valid = 1'b1;
    rd_seen = 0; rdy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (q_rd_en) rd_seen++;
      if (in_ready) rdy_seen++;
    end
    in_valid = 1'b0;
    chk("done_no_reads", rd_seen, 0);
    chk("done_no_ready", rdy_seen, 0);
    chk("done_held", 32'(done), 32'd1);
    chk("done_count_frozen", update_count, 32'd1);
    chk("done_single_write", wr_total - w0, 1);

    // stop while IDLE blocks the offered tuple and goes to DONE
    do_reset();
    stop = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("idle_stop_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("idle_stop_done", 32'(done), 32'd1);
    chk("idle_stop_no_read", 32'(q_rd_en), 32'd0);

    // rst during WAIT aborts without write-back
    do_reset();
    in_state = 8'd30; in_next = 8'd31; in_action = 2'd2; in_reward = 16'd9;
    calc_L = 4;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    st_cyc = 0;
    while (!calc_start && st_cyc < 30) begin
      @(negedge clk);
      st_cyc++;
    end
    chk("rstwait_calc_start_seen", 32'(calc_start), 32'd1);
    repeat (2) @(negedge clk);
    chk("rstwait_in_wait_busy", 32'(busy), 32'd1);
    w0 = wr_total;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstwait_busy", 32'(busy), 32'd0);
    chk("rstwait_in_ready", 32'(in_ready), 32'd1);
    chk("rstwait_update_count", update_count, 32'd0);
    wr_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (q_wr_en) wr_seen++;
    end
    chk("rstwait_no_wr_strobe", wr_seen, 0);
    chk("rstwait_no_ram_write", wr_total - w0, 0);

    // Randomized tuples against a shadow Q-table
    do_reset();
    for (int i = 0; i < (1 << QA); i++) model[i] = mem[i];
    stray_en = 1'b1;
    exp_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      rs = SW'($urandom_range(0, 7));
      rn = SW'($urandom_range(0, 7));
      ra_r = AW'($urandom);
      rr = DW'($urandom);
      L = $urandom_range(1, 4);
      e_sa = model[{rs, ra_r}];
      e_mx = model[{rn, AW'(0)}];
      for (int k = 1; k < NA; k++) begin
        v = model[{rn, AW'(k)}];
        if ($signed(v) > $signed(e_mx)) e_mx = v;
      end
      e_new = rr + e_mx - e_sa;
      model[{rs, ra_r}] = e_new;
      e_wa = {rs, ra_r};
      run_tuple(rs, rn, ra_r, rr, L, 0, o_sa, o_mx, o_r, o_wa, o_wd, lat, st_cyc, acc_w, ok);
      exp_cnt++;
      chk($sformatf("rnd%0d_complete", t), 32'(ok), 32'd1);
      chk($sformatf("rnd%0d_calc_q_sa", t), 32'(o_sa), 32'(e_sa));
      chk($sformatf("rnd%0d_calc_q_max", t), 32'(o_mx), 32'(e_mx));
      chk($sformatf("rnd%0d_calc_reward", t), 32'(o_r), 32'(rr));
      chk($sformatf("rnd%0d_wr_addr", t), 32'(o_wa), 32'(e_wa));
      chk($sformatf("rnd%0d_wr_data", t), 32'(o_wd), 32'(e_new));
      chk($sformatf("rnd%0d_start_cycle", t), st_cyc, NA + 3);
      chk($sformatf("rnd%0d_latency", t), lat, NA + 4 + L);
      @(negedge clk);
      chk($sformatf("rnd%0d_update_count", t), update_count, exp_cnt);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    stray_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
